// File: rtl/restart_event_gen.sv
// Debounced restart-key FSM plus game-over edge strobes; RESTART_PRESS_COUNT_EN adds a saturating press_count output.
// Latency: key_n sampled low at edge N -> restart_pulse after edge N+2+DEBOUNCE_CYCLES; no backpressure, all strobes last one cycle.
module restart_event_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       key_n,
  input  logic       game_over2,
  input  logic       game_over3,
  output logic       restart_pulse,
  output logic       go2_pulse,
  output logic       go3_pulse,
  output logic       busy
`ifdef RESTART_PRESS_COUNT_EN
  ,
  output logic [7:0] press_count
`endif
);

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        key_s;
  logic        deb_state_q, deb_state_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        restart_pulse_q, restart_pulse_d;
  logic        busy_q, busy_d;
  logic        go2_prev_q, go2_prev_d;
  logic        go3_prev_q, go3_prev_d;
  logic        go2_pulse_q, go2_pulse_d;
  logic        go3_pulse_q, go3_pulse_d;

  // Synchronizer idles at key_n=1 (not pressed); key_s is the active-high view.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    key_s   = ~sync2_q;
  end

  always_comb begin
    deb_state_d = deb_state_q;
    deb_cnt_d   = '0;
    if (key_s != deb_state_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_state_d = ~deb_state_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (deb_state_q)  state_d = PRESSED;
      PRESSED: if (!deb_state_q) state_d = LOCKOUT;
      LOCKOUT: if (hold_cnt_q == 16'd0) state_d = deb_state_q ? PRESSED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lockout spans HOLDOFF_CYCLES decrements plus the cycle that sees zero, so a
  // re-press debounced during lockout resumes in PRESSED without a strobe.
  always_comb begin
    restart_pulse_d = (state_q == IDLE) && deb_state_q;
    busy_d          = (state_d != IDLE);
    hold_cnt_d      = hold_cnt_q;
    case (state_q)
      PRESSED: if (!deb_state_q) hold_cnt_d = HOLD_LOAD;
      LOCKOUT: if (hold_cnt_q != 16'd0) hold_cnt_d = hold_cnt_q - 16'd1;
      default: hold_cnt_d = hold_cnt_q;
    endcase
  end

  always_comb begin
    go2_prev_d  = game_over2;
    go3_prev_d  = game_over3;
    go2_pulse_d = game_over2 & ~go2_prev_q;
    go3_pulse_d = game_over3 & ~go3_prev_q;
  end

  // History regs track the inputs during reset so a level held across release gives no strobe.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      deb_state_q     <= 1'b0;
      deb_cnt_q       <= '0;
      hold_cnt_q      <= '0;
      restart_pulse_q <= 1'b0;
      busy_q          <= 1'b0;
      go2_prev_q      <= game_over2;
      go3_prev_q      <= game_over3;
      go2_pulse_q     <= 1'b0;
      go3_pulse_q     <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      deb_state_q     <= deb_state_d;
      deb_cnt_q       <= deb_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      restart_pulse_q <= restart_pulse_d;
      busy_q          <= busy_d;
      go2_prev_q      <= go2_prev_d;
      go3_prev_q      <= go3_prev_d;
      go2_pulse_q     <= go2_pulse_d;
      go3_pulse_q     <= go3_pulse_d;
    end
  end

  assign restart_pulse = restart_pulse_q;
  assign go2_pulse     = go2_pulse_q;
  assign go3_pulse     = go3_pulse_q;
  assign busy          = busy_q;

`ifdef RESTART_PRESS_COUNT_EN
  logic [7:0] press_count_q, press_count_d;

  // Counts alongside the strobe so the new value appears in the pulse cycle.
  always_comb begin
    press_count_d = press_count_q;
    if (restart_pulse_d && (press_count_q != 8'hFF)) begin
      press_count_d = press_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      press_count_q <= '0;
    end else begin
      press_count_q <= press_count_d;
    end
  end

  assign press_count = press_count_q;
`endif

endmodule

// File: tb/tb_restart_event_gen.sv
// Scoreboarded random and directed bench for restart_event_gen (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=3).
module tb_restart_event_gen;
  localparam int D = 4;
  localparam int H = 3;

  logic clock_50 = 1'b0;
  logic reset = 1'b1;
  logic key_n = 1'b1;
  logic game_over2 = 1'b0;
  logic game_over3 = 1'b0;
  logic restart_pulse, go2_pulse, go3_pulse, busy;
`ifdef RESTART_PRESS_COUNT_EN
  logic [7:0] press_count;
`endif

  restart_event_gen #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H)) dut (
    .clock_50     (clock_50),
    .reset        (reset),
    .key_n        (key_n),
    .game_over2   (game_over2),
    .game_over3   (game_over3),
    .restart_pulse(restart_pulse),
    .go2_pulse    (go2_pulse),
    .go3_pulse    (go3_pulse),
    .busy         (busy)
`ifdef RESTART_PRESS_COUNT_EN
    ,
    .press_count  (press_count)
`endif
  );

  always #5 clock_50 = ~clock_50;

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  typedef struct {
    int e;
    bit busy;
    int cnt;
  } rec_t;
  rec_t bq[$];
  int   rq[$];
  int   g2q[$];
  int   g3q[$];

  // Reference model: key pressed as seen two samples late, accepted after D
  // consecutive disagreeing samples; press/lockout tracked as flags and a countdown.
  bit rst_m1 = 1'b1, rst_m2 = 1'b1, kn_m1 = 1'b1, kn_m2 = 1'b1;
  bit m_deb, m_held, m_lock, g2_prev, g3_prev;
  int m_streak, m_left, m_cnt;

  always @(posedge clock_50) begin
    bit   ks;
    rec_t r;
    ecount++;
    if (reset) begin
      m_deb = 0; m_held = 0; m_lock = 0; m_streak = 0; m_left = 0; m_cnt = 0;
    end else begin
      ks = !rst_m1 && !rst_m2 && !kn_m2;
      if (m_lock) begin
        if (m_left == 0) begin
          m_lock = 0;
          m_held = m_deb;
        end else begin
          m_left--;
        end
      end else if (!m_held) begin
        if (m_deb) begin
          m_held = 1;
          rq.push_back(ecount);
          if (m_cnt < 255) m_cnt++;
        end
      end else if (!m_deb) begin
        m_held = 0;
        m_lock = 1;
        m_left = H;
      end
      if (ks != m_deb) m_streak++;
      else m_streak = 0;
      if (m_streak == D) begin
        m_deb = !m_deb;
        m_streak = 0;
      end
      if (game_over2 && !g2_prev) g2q.push_back(ecount);
      if (game_over3 && !g3_prev) g3q.push_back(ecount);
    end
    g2_prev = game_over2;
    g3_prev = game_over3;
    rst_m2 = rst_m1; rst_m1 = reset;
    kn_m2 = kn_m1;   kn_m1 = key_n;
    r.e = ecount;
    r.busy = m_held || m_lock;
    r.cnt = m_cnt;
    bq.push_back(r);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ecount);
    end
  endtask

  task automatic pulse_chk(input string nm, input logic dut_v, input bit due);
    if (dut_v || due) begin
      checks++;
      if (dut_v !== due) begin
        errors++;
        $display("FAIL %s at edge %0d: got %b expected %b", nm, ecount, dut_v, due);
      end
    end
  endtask

  int rp_total = 0, g2_total = 0, g3_total = 0;
  int first_rp_edge = -1, first_busy_edge = -1, last_rp_edge = -1;
  int both_cnt = 0;

  always @(negedge clock_50) begin
    rec_t r;
    bit   due;
    if (bq.size() > 0) begin
      r = bq.pop_front();
      chk("busy", int'(busy), int'(r.busy));
`ifdef RESTART_PRESS_COUNT_EN
      chk("press_count", int'(press_count), r.cnt);
`endif
    end
    due = (rq.size() > 0) && (rq[0] == ecount);
    if (due) void'(rq.pop_front());
    pulse_chk("restart_pulse", restart_pulse, due);
    due = (g2q.size() > 0) && (g2q[0] == ecount);
    if (due) void'(g2q.pop_front());
    pulse_chk("go2_pulse", go2_pulse, due);
    due = (g3q.size() > 0) && (g3q[0] == ecount);
    if (due) void'(g3q.pop_front());
    pulse_chk("go3_pulse", go3_pulse, due);
    if (restart_pulse === 1'b1) begin
      rp_total++;
      last_rp_edge = ecount;
      if (first_rp_edge < 0) first_rp_edge = ecount;
    end
    if (busy === 1'b1 && first_busy_edge < 0) first_busy_edge = ecount;
    if (go2_pulse === 1'b1) g2_total++;
    if (go3_pulse === 1'b1) g3_total++;
    if (restart_pulse === 1'b1 && go2_pulse === 1'b1) both_cnt++;
  end

  task automatic step();
    @(negedge clock_50);
  endtask

  task automatic to_edge(input int n);
    while (ecount < n) step();
  endtask

  initial begin
    int base, rel;
    to_edge(3);
    reset = 0;
    // Key sampled low at edge 10 and held.
    to_edge(9);
    key_n = 0;
    to_edge(22);
    chk("first_pulse_edge", first_rp_edge, 16);
    chk("first_busy_edge", first_busy_edge, 16);
    chk("pulse_count_held", rp_total, 1);

    // Release for exactly D samples, then re-press: rise lands inside lockout.
    base = rp_total;
    key_n = 1;
    repeat (D) step();
    key_n = 0;
    repeat (20) step();
    chk("lockout_repress_no_pulse", rp_total, base);
    chk("lockout_repress_busy", int'(busy), 1);
    key_n = 1;
    repeat (20) step();
    chk("idle_after_release", int'(busy), 0);
    key_n = 0;
    repeat (20) step();
    chk("clean_repress_one_pulse", rp_total, base + 1);
    key_n = 1;
    repeat (25) step();

    // Glitch shorter than D.
    base = rp_total;
    key_n = 0;
    repeat (3) step();
    key_n = 1;
    repeat (15) step();
    chk("short_glitch_no_pulse", rp_total, base);
    chk("short_glitch_busy", int'(busy), 0);

    // go2 rise coincides with restart strobe; go3 held high 20 cycles.
    base = g3_total;
    key_n = 0;
    game_over3 = 1;
    repeat (D + 2) step();
    game_over2 = 1;
    repeat (14) step();
    game_over3 = 0;
    game_over2 = 0;
    chk("restart_go2_same_cycle", both_cnt, 1);
    chk("go3_single_pulse", g3_total, base + 1);
    key_n = 1;
    repeat (25) step();

    // game_over3 raised during reset gives no strobe after release.
    base = g3_total;
    reset = 1;
    step();
    game_over3 = 1;
    repeat (2) step();
    reset = 0;
    repeat (6) step();
    chk("go3_high_through_reset", g3_total, base);
    game_over3 = 0;

    // Reset mid-debounce with key still held.
    base = rp_total;
    key_n = 0;
    repeat (3) step();
    reset = 1;
    repeat (2) step();
    reset = 0;
    rel = ecount + 1;
    repeat (D + 8) step();
    chk("reset_mid_debounce_edge", last_rp_edge, rel + D + 2);
    chk("reset_mid_debounce_count", rp_total, base + 1);
    key_n = 1;
    repeat (25) step();

    // Randomized segments.
    for (int i = 0; i < 300; i++) begin
      key_n = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 3) == 0) game_over2 = ~game_over2;
      if ($urandom_range(0, 3) == 0) game_over3 = ~game_over3;
      repeat ($urandom_range(1, 12)) step();
    end
    reset = 0;
    key_n = 1;
    game_over2 = 0;
    game_over3 = 0;
    repeat (30) step();

    // 260 clean presses.
    base = rp_total;
    for (int i = 0; i < 260; i++) begin
      key_n = 0;
      repeat (D + 4) step();
      key_n = 1;
      repeat (D + H + 6) step();
    end
    repeat (10) step();
    chk("press_burst_pulses", rp_total, base + 260);
`ifdef RESTART_PRESS_COUNT_EN
    chk("press_count_saturated", int'(press_count), 255);
`endif
    chk("leftover_restart", rq.size(), 0);
    chk("leftover_go2", g2q.size(), 0);
    chk("leftover_go3", g3q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
